// File: rtl/mac_lookup_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | mac_arb_pkg : shared types for the MAC lookup arbiter                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mac_arb_pkg;

   typedef logic [47:0] mac_t;
   typedef logic [2:0]  port_t;

   typedef struct packed {
      mac_t  dst_mac;
      mac_t  src_mac;
      port_t src_port;
   } lkp_req_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } arb_state_t;

   localparam port_t FLOOD_PORT_C = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mac_lookup_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | mac_lookup_arbiter_if : request, table and result bundle of the arbiter  |
// | Optional MAC_ARB_STATS_EN adds statistics counters. Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mac_lookup_arbiter_if #(
   parameter int NUM_PORTS = 4
);
   import mac_arb_pkg::*;

   logic [NUM_PORTS-1:0]    req_valid;
   logic [48*NUM_PORTS-1:0] req_dst_mac;
   logic [48*NUM_PORTS-1:0] req_src_mac;
   logic [3*NUM_PORTS-1:0]  req_src_port;
   logic                    lkp_valid;
   logic                    lkp_ready;
   mac_t                    lkp_dst_mac;
   mac_t                    lkp_src_mac;
   port_t                   lkp_src_port;
   logic                    rsp_valid;
   port_t                   rsp_dst_port;
   logic [NUM_PORTS-1:0]    res_valid;
   port_t                   res_dst_port;
   logic [NUM_PORTS-1:0]    drop;
   logic                    busy;
`ifdef MAC_ARB_STATS_EN
   logic [16*NUM_PORTS-1:0] grant_cnt;
   logic [16*NUM_PORTS-1:0] drop_cnt;
   logic [15:0]             timeout_cnt;
`endif

   modport slave (
      input  req_valid, req_dst_mac, req_src_mac, req_src_port,
      input  lkp_ready, rsp_valid, rsp_dst_port,
      output lkp_valid, lkp_dst_mac, lkp_src_mac, lkp_src_port,
      output res_valid, res_dst_port, drop, busy
`ifdef MAC_ARB_STATS_EN
      , output grant_cnt, drop_cnt, timeout_cnt
`endif
   );

   modport master (
      output req_valid, req_dst_mac, req_src_mac, req_src_port,
      output lkp_ready, rsp_valid, rsp_dst_port,
      input  lkp_valid, lkp_dst_mac, lkp_src_mac, lkp_src_port,
      input  res_valid, res_dst_port, drop, busy
`ifdef MAC_ARB_STATS_EN
      , input grant_cnt, drop_cnt, timeout_cnt
`endif
   );

endinterface

`default_nettype wire

// File: rtl/mac_lookup_arbiter_req_queue.sv
// +--------------------------------------------------------------------------+
// | mac_req_queue : per-port request FIFO with push/pop/empty/drop           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_req_queue
   import mac_arb_pkg::*;
#(
   parameter int QUEUE_DEPTH = 2
) (
   input  wire       clk,
   input  wire       reset,
   input  wire       i_push,
   input  lkp_req_t  i_data,
   input  wire       i_pop,
   output lkp_req_t  o_data,
   output logic      o_empty,
   output logic      o_drop
);
   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   lkp_req_t         r_mem [QUEUE_DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_cnt;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_full    = (r_cnt == CW'(QUEUE_DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   // A full queue still accepts a push when it is being popped this cycle
   assign w_do_push = i_push & (~w_full | w_do_pop);
   assign o_drop    = i_push & w_full & ~w_do_pop & ~reset;
   assign o_data    = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= (r_wr == AW'(QUEUE_DEPTH - 1)) ? '0 : r_wr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd <= (r_rd == AW'(QUEUE_DEPTH - 1)) ? '0 : r_rd + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_lookup_arbiter.sv
// +--------------------------------------------------------------------------+
// | mac_lookup_arbiter : round-robin sharing of the MAC table between ports  |
// | Optional MAC_ARB_STATS_EN adds grant/drop/timeout counters. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_lookup_arbiter
   import mac_arb_pkg::*;
#(
   parameter int    NUM_PORTS   = 4,
   parameter int    QUEUE_DEPTH = 2,
   parameter int    RSP_TIMEOUT = 15,
   parameter port_t FLOOD_PORT  = FLOOD_PORT_C
) (
   input wire                   clk,
   input wire                   reset,
   mac_lookup_arbiter_if.slave  bus
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int TW = $clog2(RSP_TIMEOUT + 1);

   arb_state_t           r_state;
   logic [PW-1:0]        r_ptr;
   logic [PW-1:0]        r_gnt;
   logic [TW-1:0]        r_cnt;
   logic                 r_lkp_valid;
   lkp_req_t             r_lkp;
   logic [NUM_PORTS-1:0] r_res_valid;
   port_t                r_res_dst;

   lkp_req_t             w_q_data [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_empty;
   logic [NUM_PORTS-1:0] w_drop;
   logic [NUM_PORTS-1:0] w_pop;
   logic                 w_any;
   logic [PW-1:0]        w_sel;
   logic                 w_timeout;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_queue
      lkp_req_t w_q_in;
      assign w_q_in.dst_mac  = bus.req_dst_mac[48*i +: 48];
      assign w_q_in.src_mac  = bus.req_src_mac[48*i +: 48];
      assign w_q_in.src_port = bus.req_src_port[3*i +: 3];
      assign w_pop[i]        = (r_state == IDLE) & w_any & (w_sel == PW'(i));

      mac_req_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
         .clk     (clk),
         .reset   (reset),
         .i_push  (bus.req_valid[i]),
         .i_data  (w_q_in),
         .i_pop   (w_pop[i]),
         .o_data  (w_q_data[i]),
         .o_empty (w_empty[i]),
         .o_drop  (w_drop[i])
      );
   end

   // Descending scan so the last hit is the nearest port at/after r_ptr
   always_comb begin
      int idx;
      idx   = 0;
      w_any = 1'b0;
      w_sel = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = (int'(r_ptr) + k) % NUM_PORTS;
         if (!w_empty[PW'(idx)]) begin
            w_any = 1'b1;
            w_sel = PW'(idx);
         end
      end
   end

   // r_cnt starts at 0 on the cycle after the handshake and the result is
   // registered, so firing at RSP_TIMEOUT-2 lands res_valid RSP_TIMEOUT
   // cycles after the handshake.
   assign w_timeout = (r_state == WAIT_RSP) & ~bus.rsp_valid &
                      (r_cnt == TW'(RSP_TIMEOUT - 2));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_cnt       <= '0;
         r_lkp_valid <= 1'b0;
         r_lkp       <= '0;
         r_res_valid <= '0;
         r_res_dst   <= '0;
      end else begin
         r_res_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_lkp       <= w_q_data[w_sel];
                  r_lkp_valid <= 1'b1;
                  r_gnt       <= w_sel;
                  r_ptr       <= (w_sel == PW'(NUM_PORTS - 1)) ? '0 : w_sel + 1'b1;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.lkp_ready) begin
                  r_lkp_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (bus.rsp_valid) begin
                  r_res_valid[r_gnt] <= 1'b1;
                  r_res_dst          <= bus.rsp_dst_port;
                  r_state            <= IDLE;
               end else if (w_timeout) begin
                  r_res_valid[r_gnt] <= 1'b1;
                  r_res_dst          <= FLOOD_PORT;
                  r_state            <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.lkp_valid    = r_lkp_valid;
   assign bus.lkp_dst_mac  = r_lkp.dst_mac;
   assign bus.lkp_src_mac  = r_lkp.src_mac;
   assign bus.lkp_src_port = r_lkp.src_port;
   assign bus.res_valid    = r_res_valid;
   assign bus.res_dst_port = r_res_dst;
   assign bus.drop         = w_drop;
   assign bus.busy         = (r_state != IDLE) | ~(&w_empty);

`ifdef MAC_ARB_STATS_EN
   logic [15:0] r_timeout_cnt;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
      logic [15:0] r_grant_cnt;
      logic [15:0] r_drop_cnt;
      always_ff @(posedge clk) begin
         if (reset) begin
            r_grant_cnt <= '0;
            r_drop_cnt  <= '0;
         end else begin
            if (w_pop[i] && (r_grant_cnt != 16'hFFFF)) begin
               r_grant_cnt <= r_grant_cnt + 1'b1;
            end
            if (w_drop[i] && (r_drop_cnt != 16'hFFFF)) begin
               r_drop_cnt <= r_drop_cnt + 1'b1;
            end
         end
      end
      assign bus.grant_cnt[16*i +: 16] = r_grant_cnt;
      assign bus.drop_cnt[16*i +: 16]  = r_drop_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timeout_cnt <= '0;
      end else if (w_timeout && (r_timeout_cnt != 16'hFFFF)) begin
         r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end
   end
   assign bus.timeout_cnt = r_timeout_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_lookup_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mac_lookup_arbiter : scoreboard bench for mac_lookup_arbiter          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mac_lookup_arbiter;
   import mac_arb_pkg::*;

   localparam int NP = 4;
   localparam int T  = 15;

   typedef struct {
      logic [NP-1:0] oh;
      port_t         dst;
      int            dly;
   } res_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mac_lookup_arbiter_if #(.NUM_PORTS(NP)) bus();

   mac_lookup_arbiter #(
      .NUM_PORTS   (NP),
      .QUEUE_DEPTH (2),
      .RSP_TIMEOUT (T),
      .FLOOD_PORT  (3'b111)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   lkp_req_t      exp_lkp [$];
   res_t          exp_res [$];
   logic [NP-1:0] exp_drop [$];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int hs_count = 0;
   int hs_cyc   = 0;
   bit auto_rsp = 1'b1;
   int rsp_delay = 2;
   port_t rsp_val = 3'd0;

   task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: compares each DUT event against the scoreboard heads
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.lkp_valid && bus.lkp_ready) begin
            hs_count++;
            hs_cyc = cyc;
            check_val("lkp_pending", 64'(exp_lkp.size() != 0), 64'd1);
            if (exp_lkp.size() != 0) begin
               lkp_req_t e;
               e = exp_lkp.pop_front();
               check_val("lkp_dst_mac", 64'(bus.lkp_dst_mac), 64'(e.dst_mac));
               check_val("lkp_src_mac", 64'(bus.lkp_src_mac), 64'(e.src_mac));
               check_val("lkp_src_port", 64'(bus.lkp_src_port), 64'(e.src_port));
            end
         end
         if (bus.res_valid != '0) begin
            check_val("res_pending", 64'(exp_res.size() != 0), 64'd1);
            if (exp_res.size() != 0) begin
               res_t r;
               r = exp_res.pop_front();
               check_val("res_valid", 64'(bus.res_valid), 64'(r.oh));
               check_val("res_dst_port", 64'(bus.res_dst_port), 64'(r.dst));
               if (r.dly >= 0) check_val("res_latency", 64'(cyc - hs_cyc), 64'(r.dly));
            end
         end
         if (bus.drop != '0) begin
            check_val("drop_pending", 64'(exp_drop.size() != 0), 64'd1);
            if (exp_drop.size() != 0) check_val("drop_vec", 64'(bus.drop), 64'(exp_drop.pop_front()));
         end
      end
   end

   // Table model: answers rsp_delay cycles after each handshake
   initial begin
      bus.rsp_valid    = 1'b0;
      bus.rsp_dst_port = 3'd0;
      forever begin
         @(negedge clk);
         if (!reset && bus.lkp_valid && bus.lkp_ready && auto_rsp) begin
            repeat (rsp_delay) @(posedge clk);
            #1;
            bus.rsp_valid    = 1'b1;
            bus.rsp_dst_port = rsp_val;
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b0;
         end
      end
   end

   // mode: 0 expect a lookup, 1 expect a drop, 2 no expectation
   task automatic set_req(int p, mac_t d, mac_t s, port_t sp, int mode);
      logic [NP-1:0] oh;
      oh = '0;
      oh[p] = 1'b1;
      bus.req_dst_mac[48*p +: 48] = d;
      bus.req_src_mac[48*p +: 48] = s;
      bus.req_src_port[3*p +: 3]  = sp;
      bus.req_valid[p]            = 1'b1;
      if (mode == 0) exp_lkp.push_back('{dst_mac: d, src_mac: s, src_port: sp});
      else if (mode == 1) exp_drop.push_back(oh);
   endtask

   task automatic exp_r(int p, port_t dst, int dly);
      logic [NP-1:0] oh;
      oh = '0;
      oh[p] = 1'b1;
      exp_res.push_back('{oh: oh, dst: dst, dly: dly});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.req_valid = '0;
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      bus.req_valid = '0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_idle(int budget);
      int n;
      n = 0;
      @(negedge clk);
      while ((bus.busy || exp_res.size() != 0 || exp_lkp.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_busy", 64'(bus.busy), 64'd0);
      check_val("idle_res_left", 64'(exp_res.size()), 64'd0);
      check_val("idle_lkp_left", 64'(exp_lkp.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(int target, int budget);
      int n;
      n = 0;
      while (hs_count < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_val("hs_wait", 64'(hs_count), 64'(target));
   endtask

   initial begin
      int base;
      int n;
      bus.req_valid    = '0;
      bus.req_dst_mac  = '0;
      bus.req_src_mac  = '0;
      bus.req_src_port = '0;
      bus.lkp_ready    = 1'b1;

      // Reset state
      do_reset(3);
      @(negedge clk);
      check_val("rst_lkp_valid", 64'(bus.lkp_valid), 64'd0);
      check_val("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check_val("rst_drop", 64'(bus.drop), 64'd0);
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_lkp_dst", 64'(bus.lkp_dst_mac), 64'd0);
      @(posedge clk);
      #1;

      // Single request with latency
      auto_rsp = 1'b1; rsp_delay = 2; rsp_val = 3'd1;
      exp_r(2, 3'd1, 3);
      set_req(2, 48'h0A0B0C0D0E0F, 48'h112233445566, 3'd2, 0);
      tick();
      @(negedge clk);
      check_val("lat_n1_lkp_valid", 64'(bus.lkp_valid), 64'd0);
      @(negedge clk);
      check_val("lat_n2_lkp_valid", 64'(bus.lkp_valid), 64'd1);
      wait_idle(40);

      // Round-robin fairness from a fresh reset
      do_reset(2);
      rsp_delay = 1; rsp_val = 3'd5;
      base = hs_count;
      for (int p = 0; p < NP; p++) begin
         set_req(p, 48'hD000_0000_0000 + 48'(p), 48'h5000_0000_0000 + 48'(p), port_t'(p), 0);
         exp_r(p, 3'd5, 2);
      end
      tick();
      wait_hs(base + 2, 40);
      set_req(0, 48'hD0D0_0000_00AA, 48'h5050_0000_00AA, 3'd0, 0);
      exp_r(0, 3'd5, 2);
      tick();
      wait_idle(80);
      check_val("rr_hs_total", 64'(hs_count), 64'(base + 5));

      // Backpressure: lkp_* held while lkp_ready is low
      bus.lkp_ready = 1'b0;
      rsp_val = 3'd2;
      base = hs_count;
      set_req(3, 48'hBEEF_0000_0003, 48'hCAFE_0000_0003, 3'd3, 0);
      exp_r(3, 3'd2, 2);
      tick();
      n = 0;
      while (!bus.lkp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("bp_lkp_valid", 64'(bus.lkp_valid), 64'd1);
         check_val("bp_dst_mac", 64'(bus.lkp_dst_mac), 64'hBEEF_0000_0003);
         check_val("bp_src_mac", 64'(bus.lkp_src_mac), 64'hCAFE_0000_0003);
         check_val("bp_src_port", 64'(bus.lkp_src_port), 64'd3);
      end
      @(posedge clk);
      #1;
      bus.lkp_ready = 1'b1;
      wait_idle(40);
      check_val("bp_hs_once", 64'(hs_count), 64'(base + 1));

      // Overflow on port 1 while stuck in ISSUE
      bus.lkp_ready = 1'b0;
      rsp_val = 3'd6;
      base = hs_count;
      set_req(0, 48'h0000_0000_1000, 48'h0000_0000_2000, 3'd0, 0);
      exp_r(0, 3'd6, 2);
      tick();
      repeat (2) @(posedge clk);
      #1;
      set_req(1, 48'h0000_0000_1101, 48'h0000_0000_2101, 3'd1, 0);
      exp_r(1, 3'd6, 2);
      tick();
      set_req(1, 48'h0000_0000_1102, 48'h0000_0000_2102, 3'd1, 0);
      exp_r(1, 3'd6, 2);
      tick();
      set_req(1, 48'h0000_0000_1103, 48'h0000_0000_2103, 3'd1, 1);
      tick();
      bus.lkp_ready = 1'b1;
      wait_idle(80);
      check_val("ovf_hs_total", 64'(hs_count), 64'(base + 3));
      check_val("ovf_drop_left", 64'(exp_drop.size()), 64'd0);

      // Timeout with no answer, then answer on the timeout cycle
      auto_rsp = 1'b0;
      exp_r(2, 3'b111, T);
      set_req(2, 48'hAAAA_0000_0002, 48'hBBBB_0000_0002, 3'd2, 0);
      tick();
      wait_idle(60);
      auto_rsp = 1'b1; rsp_delay = T - 1; rsp_val = 3'd4;
      exp_r(2, 3'd4, T);
      set_req(2, 48'hAAAA_0000_0012, 48'hBBBB_0000_0012, 3'd2, 0);
      tick();
      wait_idle(60);

      // Reset while waiting for a response with two entries queued
      do_reset(2);
      rsp_delay = 6; rsp_val = 3'd3;
      base = hs_count;
      set_req(1, 48'h0101_0101_0101, 48'h0202_0202_0202, 3'd1, 0);
      tick();
      wait_hs(base + 1, 10);
      set_req(2, 48'h0303_0303_0303, 48'h0404_0404_0404, 3'd2, 2);
      set_req(3, 48'h0505_0505_0505, 48'h0606_0606_0606, 3'd3, 2);
      tick();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_val("mrst_busy", 64'(bus.busy), 64'd0);
      check_val("mrst_res_valid", 64'(bus.res_valid), 64'd0);
      check_val("mrst_lkp_valid", 64'(bus.lkp_valid), 64'd0);
      check_val("mrst_res_dst", 64'(bus.res_dst_port), 64'd0);
      check_val("mrst_lkp_port", 64'(bus.lkp_src_port), 64'd0);
      @(posedge clk);
      #1;
      rsp_delay = 1; rsp_val = 3'd2;
      set_req(1, 48'h0707_0707_0701, 48'h0808_0808_0801, 3'd1, 0);
      set_req(3, 48'h0707_0707_0703, 48'h0808_0808_0803, 3'd3, 0);
      exp_r(1, 3'd2, 2);
      exp_r(3, 3'd2, 2);
      tick();
      wait_idle(60);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
